// File: rtl/decode_issue.sv
// decode_issue: RV32I ALU-subset decode and issue stage.
//   Decodes R-type and I-type ALU instructions and reads operands from a
//   32x32 register file. A per-register busy scoreboard stalls any
//   instruction whose source register still awaits writeback. Each accepted
//   op is handed to Exec over a valid/ready handshake with one cycle of
//   latency. Unsupported encodings are accepted and dropped, and `illegal`
//   pulses for one cycle.
// Ports:
//   clk, rst                       clock, async active-high reset
//   instr, instr_valid/instr_ready instruction input handshake
//   wb_en, wb_addr, wb_data        writeback: regfile write + busy clear
//   Operand1, Operand2, Operation  issued op toward Exec
//   rd, out_valid/out_ready        destination + issue handshake
//   illegal                        one-cycle pulse for a dropped encoding
// Config macro: WB_BYPASS_EN -- forward a same-cycle writeback into the
//   operand read instead of stalling for one cycle.
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic [31:0] Operand1,
    output logic [31:0] Operand2,
    output logic [3:0]  Operation,
    output logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        illegal
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                           OP_OR  = 4'd3, OP_XOR = 4'd4, OP_SLL = 4'd5,
                           OP_SRL = 4'd6, OP_SRA = 4'd7, OP_SLT = 4'd8;
    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011;
    localparam logic [6:0] F7_0 = 7'b0000000, F7_ALT = 7'b0100000;

    logic [31:0] regs_q [32];
    logic [31:0] busy_q;
    logic [31:0] op1_q, op2_q;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic        out_valid_q, illegal_q;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] f3     = instr[14:12];
    wire [6:0] f7     = instr[31:25];
    wire [4:0] rs1    = instr[19:15];
    wire [4:0] rs2    = instr[24:20];
    wire       is_r   = (opcode == OPC_R);
    wire       is_i   = (opcode == OPC_I);

    logic        legal;
    logic [3:0]  op_d;
    logic [31:0] imm;

    // Decode. R-type ALT funct7 selects SUB/SRA; shift-immediates need a
    // valid funct7 as well, so anything else falls through as illegal.
    always_comb begin
        legal = 1'b0;
        op_d  = OP_ADD;
        case (f3)
            3'b000: begin
                if (is_i || f7 == F7_0) begin legal = 1'b1; op_d = OP_ADD; end
                else if (f7 == F7_ALT)  begin legal = 1'b1; op_d = OP_SUB; end
            end
            3'b111: begin legal = 1'b1; op_d = OP_AND; end
            3'b110: begin legal = 1'b1; op_d = OP_OR;  end
            3'b100: begin legal = 1'b1; op_d = OP_XOR; end
            3'b010: begin legal = 1'b1; op_d = OP_SLT; end
            3'b001: begin legal = (f7 == F7_0); op_d = OP_SLL; end
            3'b101: begin
                if (f7 == F7_0)        begin legal = 1'b1; op_d = OP_SRL; end
                else if (f7 == F7_ALT) begin legal = 1'b1; op_d = OP_SRA; end
            end
            default: ;
        endcase
        // R/I funct3 legality differs only for 000 (I has no SUB form).
        if (is_i && f3 == 3'b000) op_d = OP_ADD;
        if (!(is_r || is_i)) legal = 1'b0;
        // Shifts take a 5-bit unsigned amount; everything else sign-extends.
        if (f3 == 3'b001 || f3 == 3'b101) imm = {27'd0, instr[24:20]};
        else                              imm = {{20{instr[31]}}, instr[31:20]};
    end

    // Operand read and hazard detection. x0 is never busy and never written.
    wire use1  = legal;
    wire use2  = legal && is_r;
    wire hit1  = wb_en && (wb_addr == rs1) && (rs1 != 5'd0);
    wire hit2  = wb_en && (wb_addr == rs2) && (rs2 != 5'd0);
    logic [31:0] rs1_val, rs2_val;
    logic        stall;
    always_comb begin
`ifdef WB_BYPASS_EN
        rs1_val = hit1 ? wb_data : regs_q[rs1];
        rs2_val = hit2 ? wb_data : regs_q[rs2];
        stall   = (use1 && busy_q[rs1] && !hit1) || (use2 && busy_q[rs2] && !hit2);
`else
        // Without forwarding a source being written this cycle waits one
        // cycle and then reads the freshly written register file.
        rs1_val = regs_q[rs1];
        rs2_val = regs_q[rs2];
        stall   = (use1 && (busy_q[rs1] || hit1)) || (use2 && (busy_q[rs2] || hit2));
`endif
    end

    assign instr_ready = !rst && !stall && (!out_valid_q || out_ready);
    wire accept = instr_valid && instr_ready;
    wire issue  = accept && legal;
    wire [4:0] dst = instr[11:7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            busy_q      <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            illegal_q <= accept && !legal;
            if (issue) begin
                out_valid_q <= 1'b1;
                op1_q       <= rs1_val;
                op2_q       <= is_r ? rs2_val : imm;
                op_q        <= op_d;
                rd_q        <= dst;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (wb_en && wb_addr != 5'd0) begin
                regs_q[wb_addr] <= wb_data;
                busy_q[wb_addr] <= 1'b0;
            end
            // Placed after the clear so a same-cycle issue keeps the bit set.
            if (issue && dst != 5'd0) busy_q[dst] <= 1'b1;
        end
    end

    assign Operand1  = op1_q;
    assign Operand2  = op2_q;
    assign Operation = op_q;
    assign rd        = rd_q;
    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
endmodule
